// File: rtl/axil_dma_pkg.sv
// Shared state encoding and AXI-Lite constants for the word-copy engine.
package axil_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_FINISH
  } state_t;

  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [1:0] RESP_SLVERR    = 2'b10;
  localparam logic [2:0] AXPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_dma_copy.sv
// AXI-Lite word copy engine: one read then one write per word, single transaction in flight.
// Latency: busy/arvalid one cycle after start; 4 cycles per word on a zero-wait slave plus 1 done cycle.
// Backpressure: each valid holds until its own handshake. AXIL_DMA_ERR_ABORT_EN stops at the first error response.
module axil_dma_copy
  import axil_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

`ifdef AXIL_DMA_ERR_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, dst_q;
  logic [CNT_WIDTH-1:0]    rem_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    error_q;
  logic                    aw_done_q, w_done_q;
  logic                    rd_err, wr_err, aw_hs, w_hs;

  assign rd_err = (m_rresp != RESP_OKAY);
  assign wr_err = (m_bresp != RESP_OKAY);
  assign aw_hs  = m_awvalid && m_awready;
  assign w_hs   = m_wvalid && m_wready;

  assign m_araddr = src_q;
  assign m_awaddr = dst_q;
  assign m_wdata  = data_q;
  assign m_wstrb  = '1;
  assign m_arprot = AXPROT_DEFAULT;
  assign m_awprot = AXPROT_DEFAULT;
  assign error    = error_q;

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (count == '0) ? ST_FINISH : ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        busy      = 1'b1;
        m_arvalid = 1'b1;
        if (m_arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        busy     = 1'b1;
        m_rready = 1'b1;
        if (m_rvalid) state_d = (ABORT_EN && rd_err) ? ST_FINISH : ST_WR_REQ;
      end
      ST_WR_REQ: begin
        // AW and W may complete in either order; leave only once both are in.
        busy      = 1'b1;
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
        if ((aw_done_q || m_awready) && (w_done_q || m_wready)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        busy     = 1'b1;
        m_bready = 1'b1;
        if (m_bvalid) begin
          state_d = ((rem_q == CNT_WIDTH'(1)) || (ABORT_EN && wr_err)) ? ST_FINISH : ST_RD_ADDR;
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      error_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        src_q   <= src_addr & WORD_MASK;
        dst_q   <= dst_addr & WORD_MASK;
        rem_q   <= count;
        error_q <= 1'b0;
      end
      if (state_q == ST_RD_DATA && m_rvalid) begin
        data_q <= m_rdata;
        if (rd_err) error_q <= 1'b1;
      end
      if (state_q == ST_WR_REQ) begin
        if (state_d == ST_WR_RESP) begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end else begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
      end
      if (state_q == ST_WR_RESP && m_bvalid) begin
        if (wr_err) error_q <= 1'b1;
        src_q <= src_q + WORD_STEP;
        dst_q <= dst_q + WORD_STEP;
        rem_q <= rem_q - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axil_dma_copy.sv
// Bench for axil_dma_copy: reactive AXI-Lite slave with per-channel stalls and read-error injection,
// read/write scoreboards, a vector table and hand-written reset sequences.
module tb_axil_dma_copy;

  logic        clk, rst, start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] count;
  logic        busy, done, error;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  axil_dma_copy dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
    .busy(busy), .done(done), .error(error),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] cnt;
    int          ad;
    int          wd;
    int          err_rd;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic        exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [31:0] rd_q[$];
  wr_t         wr_q[$];

  int aw_delay = 0, w_delay = 0, err_rd = -1;
  int rd_idx = 0, n_rd = 0, n_wr = 0, proto = 0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: decides readies/valids at each negedge for the coming posedge; DUT valids are register-driven.
  initial begin
    logic        r_pend, b_pend, aw_seen, w_seen, ar_hold, aw_hold, w_hold;
    logic [31:0] r_addr, aw_addr, w_data;
    int          aw_wait, w_wait;
    wr_t         e;
    r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0; ar_hold = 0; aw_hold = 0; w_hold = 0;
    r_addr = 0; aw_addr = 0; w_data = 0; aw_wait = 0; w_wait = 0;
    m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
    m_rdata = 0; m_rresp = 0; m_bresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0; ar_hold = 0; aw_hold = 0; w_hold = 0;
        aw_wait = 0; w_wait = 0;
        m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
        m_rdata = 0; m_rresp = 0; m_bresp = 0;
      end else begin
        if (ar_hold && !m_arvalid) proto++;
        if (aw_hold && !m_awvalid) proto++;
        if (w_hold && !m_wvalid) proto++;
        if (m_rready && !r_pend) proto++;
        if (m_bready && !b_pend) proto++;
        m_rvalid = r_pend;
        m_rdata  = r_pend ? rd_word(r_addr) : 32'h0;
        m_rresp  = (r_pend && rd_idx == err_rd) ? 2'b10 : 2'b00;
        if (r_pend && m_rready) begin
          r_pend = 0;
          rd_idx++;
        end
        m_bvalid = b_pend;
        m_bresp  = 2'b00;
        if (b_pend && m_bready) b_pend = 0;
        m_arready = m_arvalid;
        ar_hold   = 0;
        if (m_arvalid) begin
          n_rd++;
          r_pend = 1;
          r_addr = m_araddr;
          if (rd_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL rd_extra: got read at 0x%0h, expected none", m_araddr);
          end else chk("rd_addr", 64'(m_araddr), 64'(rd_q.pop_front()));
        end
        m_awready = m_awvalid && (aw_wait >= aw_delay);
        aw_hold   = m_awvalid && !m_awready;
        if (m_awvalid) begin
          if (m_awready) begin
            if (aw_seen) proto++;
            aw_seen = 1; aw_addr = m_awaddr; aw_wait = 0;
          end else aw_wait++;
        end
        m_wready = m_wvalid && (w_wait >= w_delay);
        w_hold   = m_wvalid && !m_wready;
        if (m_wvalid) begin
          if (m_wready) begin
            if (w_seen || m_wstrb != 4'hF) proto++;
            w_seen = 1; w_data = m_wdata; w_wait = 0;
          end else w_wait++;
        end
        if (aw_seen && w_seen) begin
          aw_seen = 0; w_seen = 0; b_pend = 1; n_wr++;
          if (wr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL wr_extra: got write 0x%0h at 0x%0h, expected none", w_data, aw_addr);
          end else begin
            e = wr_q.pop_front();
            chk("wr_addr", 64'(aw_addr), 64'(e.addr));
            chk("wr_data", 64'(w_data), 64'(e.data));
          end
        end
      end
    end
  end

  task automatic prep(input vec_t v);
    aw_delay = v.ad; w_delay = v.wd; err_rd = v.err_rd;
    rd_idx = 0; n_rd = 0; n_wr = 0; proto = 0;
    for (int i = 0; i < v.exp_rd; i++) rd_q.push_back((v.src & ~32'h3) + 32'(4 * i));
    for (int i = 0; i < v.exp_wr; i++)
      wr_q.push_back('{(v.dst & ~32'h3) + 32'(4 * i), rd_word((v.src & ~32'h3) + 32'(4 * i))});
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int lat;
    bit got;
    prep(v);
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; count = v.cnt; start = 1;
    @(negedge clk);
    // A second start while busy must be ignored.
    src_addr = 32'hDEAD_BEE0; dst_addr = 32'hDEAD_0000; count = 16'd7;
    chk($sformatf("v%0d_busy_n1", id), 64'(busy), 64'(v.cnt != 0));
    chk($sformatf("v%0d_arvalid_n1", id), 64'(m_arvalid), 64'(v.cnt != 0));
    lat = 1; got = 0;
    while (!got && lat < 500) begin
      if (done === 1'b1) got = 1;
      else begin
        @(negedge clk);
        start = 0;
        lat++;
      end
    end
    start = 0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL v%0d_timeout: got no done in %0d cycles, expected done at %0d", id, lat, v.exp_lat);
    end else begin
      chk($sformatf("v%0d_latency", id), 64'(lat), 64'(v.exp_lat));
      chk($sformatf("v%0d_error", id), 64'(error), 64'(v.exp_err));
      chk($sformatf("v%0d_busy_done", id), 64'(busy), 64'd0);
    end
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", id), 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_nreads", id), 64'(n_rd), 64'(v.exp_rd));
    chk($sformatf("v%0d_nwrites", id), 64'(n_wr), 64'(v.exp_wr));
    chk($sformatf("v%0d_sb_left", id), 64'(wr_q.size() + rd_q.size()), 64'd0);
    chk($sformatf("v%0d_protocol", id), 64'(proto), 64'd0);
    wr_q.delete();
    rd_q.delete();
  endtask

  vec_t vecs[8];
  vec_t mid;

  initial begin
    int k;
    rst = 1; start = 0; src_addr = 0; dst_addr = 0; count = 0;
    vecs[0] = '{32'h1000_0000, 32'h1000_0100, 16'd3, 0, 0, -1, 13, 3, 3, 1'b0};
    vecs[1] = '{32'h1000_0000, 32'h1000_0100, 16'd0, 0, 0, -1, 1, 0, 0, 1'b0};
    vecs[2] = '{32'h2000_0000, 32'h2000_0800, 16'd2, 0, 3, -1, 15, 2, 2, 1'b0};
    vecs[3] = '{32'h2000_0040, 32'h2000_0900, 16'd2, 3, 0, -1, 15, 2, 2, 1'b0};
`ifdef AXIL_DMA_ERR_ABORT_EN
    vecs[4] = '{32'h3000_0000, 32'h3000_0100, 16'd4, 0, 0, 1, 7, 2, 1, 1'b1};
`else
    vecs[4] = '{32'h3000_0000, 32'h3000_0100, 16'd4, 0, 0, 1, 17, 4, 4, 1'b1};
`endif
    vecs[5] = '{32'hFFFF_FFFC, 32'h4000_0000, 16'd2, 0, 0, -1, 9, 2, 2, 1'b0};
    vecs[6] = '{32'h1000_0003, 32'h3000_0002, 16'd1, 0, 0, -1, 5, 1, 1, 1'b0};
    vecs[7] = '{32'h5000_0000, 32'h5000_1000, 16'd5, 1, 2, -1, 31, 5, 5, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_valids", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 64'd0);
    chk("rst_flags", 64'({busy, done, error}), 64'd0);
    chk("rst_addrs", {m_araddr, m_awaddr}, 64'd0);
    chk("rst_wdata", 64'(m_wdata), 64'd0);
    chk("const_prot_strb", 64'({m_arprot, m_awprot, m_wstrb}), 64'h00F);
    rst = 0;
    @(negedge clk);
    chk("idle_outputs", 64'({m_arvalid, m_awvalid, m_wvalid, busy, done}), 64'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset while parked in WR_REQ with awvalid high, then a clean transfer.
    mid = '{32'h6000_0000, 32'h6000_0100, 16'd2, 5, 5, -1, 0, 1, 0, 1'b0};
    prep(mid);
    @(negedge clk);
    src_addr = mid.src; dst_addr = mid.dst; count = mid.cnt; start = 1;
    @(negedge clk);
    start = 0;
    k = 0;
    while (!m_awvalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_awvalid_seen", 64'(m_awvalid), 64'd1);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_ctrl", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, busy, done, error}), 64'd0);
    chk("mid_rst_addrs", {m_araddr, m_awaddr}, 64'd0);
    chk("mid_rst_wdata", 64'(m_wdata), 64'd0);
    rst = 0;
    wr_q.delete();
    rd_q.delete();
    @(negedge clk);
    mid = '{32'h7000_0010, 32'h7000_0200, 16'd2, 0, 0, -1, 9, 2, 2, 1'b0};
    run_vec(mid, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
